// File: rtl/serial_sub_8.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Result and borrow-out are loaded only at the completion edge and held until the next one.
module serial_sub_8 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               br_q, br_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;

  logic ai, bi, dbit, nbr;

  always_comb begin
    ai   = a_q[0];
    bi   = b_q[0];
    dbit = ai ^ bi ^ br_q;
    nbr  = (~ai & bi) | (~(ai ^ bi) & br_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    res_d   = res_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = nbr;
        // Difference bits enter at the MSB so bit 0 lands in the LSB after WIDTH shifts.
        res_d = {dbit, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StDone;
          diff_d  = {dbit, res_q[WIDTH-1:1]};
          bout_d  = nbr;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      res_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy = (state_q == StShift);
  assign done = (state_q == StDone);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub_8.sv
// Self-checking bench for serial_sub_8 at WIDTH=8 and WIDTH=16 against an arithmetic model.
module tb_serial_sub_8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  a, b;
  logic        bin;
  logic        busy, done;
  logic [7:0]  diff;
  logic        bout;

  logic        start16;
  logic [15:0] a16, b16;
  logic        bin16;
  logic        busy16, done16;
  logic [15:0] diff16;
  logic        bout16;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_sub_8 #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
  );

  serial_sub_8 #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .bin(bin16),
    .busy(busy16), .done(done16), .diff(diff16), .bout(bout16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: unsigned subtraction modulo 2^w, borrow when a < b + bin.
  function automatic logic [32:0] model(input longint unsigned ma, input longint unsigned mb,
                                        input longint unsigned mbin, input int w);
    longint unsigned m, d;
    logic [32:0] r;
    m = (64'd1 << w) - 1;
    d = (ma - mb - mbin) & m;
    r = '0;
    r[31:0] = d[31:0];
    r[32]   = (ma < mb + mbin);
    return r;
  endfunction

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                     input bit disturb, input bit verbose);
    logic [32:0] exp;
    int n, busy_cnt;
    logic [7:0] held;
    exp = model(ta, tb, tbin, 8);
    @(negedge clk);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (verbose) check("busy_after_start", busy, 1'b1);
    n = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && n < 20) begin
      @(negedge clk);
      if (disturb) begin
        start = 1'($urandom); a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      end
      @(posedge clk); #1;
      n++;
      if (busy) busy_cnt++;
    end
    if (verbose) begin
      check("done_latency", n, 8);
      check("busy_cycles", busy_cnt, 8);
      check("busy_in_done", busy, 1'b0);
    end else if (n >= 20) begin
      check("done_timeout", n, 8);
    end
    check("diff", diff, exp[7:0]);
    check("bout", bout, exp[32]);
    held = diff;
    // Start presented while in DONE must be ignored.
    @(negedge clk);
    start = disturb ? 1'b1 : 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    if (verbose) begin
      check("done_one_cycle", done, 1'b0);
      check("start_in_done_ignored", busy, 1'b0);
    end
    @(posedge clk); #1;
    if (verbose) begin
      check("idle_after_done", busy | done, 1'b0);
      check("diff_held", diff, held);
    end
  endtask

  task automatic op16(input logic [15:0] ta, input logic [15:0] tb, input logic tbin);
    logic [32:0] exp;
    int n;
    exp = model(ta, tb, tbin, 16);
    @(negedge clk);
    a16 = ta; b16 = tb; bin16 = tbin; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    n = 0;
    while (!done16 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("w16_latency", n, 16);
    check("w16_diff", diff16, exp[15:0]);
    check("w16_bout", bout16, exp[32]);
    @(posedge clk); #1;
  endtask

  initial begin
    int dones;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_diff", diff, 8'h00);
    check("rst_bout", bout, 1'b0);
    check("rst_w16", {busy16, done16, bout16, diff16}, 19'h0);
    @(negedge clk);
    rst_n = 1'b1;

    op8(8'h05, 8'h03, 1'b0, 1'b0, 1'b1);
    op8(8'h81, 8'h01, 1'b1, 1'b0, 1'b1);
    op8(8'hFF, 8'h7F, 1'b1, 1'b0, 1'b1);
    op8(8'h7F, 8'h7F, 1'b1, 1'b0, 1'b1);
    op8(8'h00, 8'h01, 1'b0, 1'b0, 1'b1);
    op8(8'hA5, 8'h3C, 1'b1, 1'b1, 1'b1);

    // Count done pulses across a disturbed operation.
    dones = 0;
    fork
      begin
        op8(8'h10, 8'h20, 1'b0, 1'b1, 1'b0);
      end
      begin
        repeat (14) begin
          @(posedge clk); #2;
          if (done) dones++;
        end
      end
    join
    check("single_done_pulse", dones, 1);

    // Reset in the middle of an operation.
    @(negedge clk);
    a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_diff", diff, 8'h00);
    check("midrst_bout", bout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("midrst_no_done", dones, 0);
    op8(8'h42, 8'h17, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0);
    end

    op16(16'h0000, 16'hFFFF, 1'b1);
    for (int i = 0; i < 20; i++) begin
      op16(16'($urandom), 16'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
